dual_port_blockram_arbiter: RTL and testbench

//  Controller in front of one dual-port block RAM (one read port, one write-with-evict port).

---
 rtl/dual_port_blockram_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_dual_port_blockram_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_blockram_arbiter.sv
// dual_port_blockram_arbiter
//   Controller in front of one dual-port block RAM with a read port and a
//   write-with-evict port. Two requesters share the RAM through independent
//   round-robin arbiters, one per RAM port, so a reader and a writer can both
//   be granted in the same cycle. After reset, and again on a flush command,
//   every set is swept and written with zero. During a flush the evicted
//   contents of each set are streamed out.
//
//   Optional feature macro: DUAL_PORT_BLOCKRAM_ARBITER_RAW_FORWARD_EN
//     defined   : a read and a write granted to the same set in the same cycle
//                 return the new write data on the read response.
//     undefined : such a read returns the old RAM contents.
//
// Ports (W = SINGLE_ELEMENT_SIZE_IN_BITS, A = SET_PTR_WIDTH_IN_BITS)
//   clk_in, reset_n_in          clock, asynchronous active-low reset
//   req_valid/write/set_addr/element_in  per-requester request (bit/slice i = requester i)
//   req_ready_out               grant this cycle (valid & ready)
//   resp_valid/element_out      response one cycle after grant (read data or evicted data)
//   flush_in                    single-cycle flush command (honoured in RUN only)
//   flush_evict_*_out           evicted set stream during a flush sweep
//   flush_done_out              pulse with the last evicted element
//   init_done_out               high while in RUN
//   ram_*                       RAM control/data; RAM read and evict data return one cycle later
module dual_port_blockram_arbiter #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = 6
) (
  input  logic                                     clk_in,
  input  logic                                     reset_n_in,
  input  logic [1:0]                               req_valid_in,
  input  logic [1:0]                               req_write_in,
  input  logic [2*SET_PTR_WIDTH_IN_BITS-1:0]       req_set_addr_in,
  input  logic [2*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] req_element_in,
  output logic [1:0]                               req_ready_out,
  output logic [1:0]                               resp_valid_out,
  output logic [2*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] resp_element_out,
  input  logic                                     flush_in,
  output logic                                     flush_evict_valid_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]         flush_evict_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   flush_evict_element_out,
  output logic                                     flush_done_out,
  output logic                                     init_done_out,
  output logic                                     ram_read_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]         ram_read_set_addr_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   ram_read_element_in,
  output logic                                     ram_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]         ram_write_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   ram_write_element_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   ram_evict_element_in
);

  localparam int W = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int A = SET_PTR_WIDTH_IN_BITS;
  localparam logic [A-1:0] LAST_SET = A'(NUMBER_SETS - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [A-1:0]   counter_reg, counter_next;
  logic           rd_ptr_reg, wr_ptr_reg;
  logic [1:0]     rd_cand, wr_cand;
  logic [1:0]     rd_grant, wr_grant;
  logic [1:0]     rd_grant_reg, wr_grant_reg;
  logic           flush_evict_valid_reg;
  logic [A-1:0]   flush_evict_addr_reg;
  logic           flush_done_reg;
  logic [A-1:0]   req_addr [2];
  logic [W-1:0]   req_data [2];
  logic [W-1:0]   read_data [2];

  // Two-way round robin: a sole candidate always wins; on contention the
  // pointer names the winner.
  function automatic logic [1:0] rr_pick(input logic [1:0] cand, input logic ptr);
    case (cand)
      2'b01:   rr_pick = 2'b01;
      2'b10:   rr_pick = 2'b10;
      2'b11:   rr_pick = ptr ? 2'b10 : 2'b01;
      default: rr_pick = 2'b00;
    endcase
  endfunction

  assign rd_cand = req_valid_in & ~req_write_in;
  assign wr_cand = req_valid_in & req_write_in;

  always_comb begin
    state_next             = state_reg;
    counter_next           = counter_reg;
    rd_grant               = 2'b00;
    wr_grant               = 2'b00;
    ram_read_en_out        = 1'b0;
    ram_read_set_addr_out  = '0;
    ram_write_en_out       = 1'b0;
    ram_write_set_addr_out = '0;
    ram_write_element_out  = '0;
    case (state_reg)
      ST_INIT, ST_FLUSH: begin
        // Sweep: zero one set per cycle, requesters are held off.
        ram_write_en_out       = 1'b1;
        ram_write_set_addr_out = counter_reg;
        if (counter_reg == LAST_SET) begin
          state_next   = ST_RUN;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + 1'b1;
        end
      end
      ST_RUN: begin
        rd_grant = rr_pick(rd_cand, rd_ptr_reg);
        wr_grant = rr_pick(wr_cand, wr_ptr_reg);
        if (|rd_grant) begin
          ram_read_en_out       = 1'b1;
          ram_read_set_addr_out = req_addr[rd_grant[1]];
        end
        if (|wr_grant) begin
          ram_write_en_out       = 1'b1;
          ram_write_set_addr_out = req_addr[wr_grant[1]];
          ram_write_element_out  = req_data[wr_grant[1]];
        end
        if (flush_in) begin
          state_next = ST_FLUSH;
        end
      end
      default: begin
        state_next   = ST_INIT;
        counter_next = '0;
      end
    endcase
  end

  assign req_ready_out = rd_grant | wr_grant;
  assign init_done_out = (state_reg == ST_RUN);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_reg             <= ST_INIT;
      counter_reg           <= '0;
      rd_ptr_reg            <= 1'b0;
      wr_ptr_reg            <= 1'b0;
      rd_grant_reg          <= 2'b00;
      wr_grant_reg          <= 2'b00;
      flush_evict_valid_reg <= 1'b0;
      flush_evict_addr_reg  <= '0;
      flush_done_reg        <= 1'b0;
    end else begin
      state_reg    <= state_next;
      counter_reg  <= counter_next;
      // The pointer moves to the requester that just lost (or was idle).
      if (|rd_grant) begin
        rd_ptr_reg <= ~rd_grant[1];
      end
      if (|wr_grant) begin
        wr_ptr_reg <= ~wr_grant[1];
      end
      rd_grant_reg <= rd_grant;
      wr_grant_reg <= wr_grant;
      // Evict data of the sweep write appears on the RAM one cycle later;
      // track the set so the stream stays aligned with it.
      flush_evict_valid_reg <= (state_reg == ST_FLUSH);
      if (state_reg == ST_FLUSH) begin
        flush_evict_addr_reg <= counter_reg;
      end
      flush_done_reg <= (state_reg == ST_FLUSH) && (counter_reg == LAST_SET);
    end
  end

`ifdef DUAL_PORT_BLOCKRAM_ARBITER_RAW_FORWARD_EN
  // Read-after-write bypass: remember which reader collided with the
  // concurrent write and the data that was written.
  logic [1:0]   fwd_sel_reg;
  logic [W-1:0] fwd_data_reg;
  logic         raw_hit;

  assign raw_hit = (|rd_grant) && (|wr_grant) &&
                   (req_addr[rd_grant[1]] == req_addr[wr_grant[1]]);

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      fwd_sel_reg  <= 2'b00;
      fwd_data_reg <= '0;
    end else begin
      fwd_sel_reg <= raw_hit ? rd_grant : 2'b00;
      if (raw_hit) begin
        fwd_data_reg <= req_data[wr_grant[1]];
      end
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_addr[gi] = req_set_addr_in[gi*A +: A];
      assign req_data[gi] = req_element_in[gi*W +: W];
`ifdef DUAL_PORT_BLOCKRAM_ARBITER_RAW_FORWARD_EN
      assign read_data[gi] = fwd_sel_reg[gi] ? fwd_data_reg : ram_read_element_in;
`else
      assign read_data[gi] = ram_read_element_in;
`endif
      assign resp_element_out[gi*W +: W] =
        wr_grant_reg[gi] ? ram_evict_element_in :
        rd_grant_reg[gi] ? read_data[gi] : '0;
    end
  endgenerate

  assign resp_valid_out          = rd_grant_reg | wr_grant_reg;
  assign flush_evict_valid_out   = flush_evict_valid_reg;
  assign flush_evict_addr_out    = flush_evict_addr_reg;
  assign flush_evict_element_out = flush_evict_valid_reg ? ram_evict_element_in : '0;
  assign flush_done_out          = flush_done_reg;

endmodule

// File: tb/tb_dual_port_blockram_arbiter.sv
// Bench for dual_port_blockram_arbiter (W=64, 4 sets, 2-bit address).
// Contains a behavioural dual-port RAM with registered read/evict data.
// Stimulus pushes expected responses into queues; a monitor on the falling
// edge pops and compares them, and also checks per-cycle expectations
// (ready, init_done, RAM write port) that the stimulus posts.
`timescale 1ns/1ps
module tb_dual_port_blockram_arbiter;
  localparam int W = 64;
  localparam int N = 4;
  localparam int A = 2;

  logic           clk_in = 1'b0;
  logic           reset_n_in = 1'b0;
  logic [1:0]     req_valid_in = 2'b00;
  logic [1:0]     req_write_in = 2'b00;
  logic [2*A-1:0] req_set_addr_in;
  logic [2*W-1:0] req_element_in;
  logic [1:0]     req_ready_out;
  logic [1:0]     resp_valid_out;
  logic [2*W-1:0] resp_element_out;
  logic           flush_in = 1'b0;
  logic           flush_evict_valid_out;
  logic [A-1:0]   flush_evict_addr_out;
  logic [W-1:0]   flush_evict_element_out;
  logic           flush_done_out;
  logic           init_done_out;
  logic           ram_read_en_out;
  logic [A-1:0]   ram_read_set_addr_out;
  logic [W-1:0]   ram_read_element_in;
  logic           ram_write_en_out;
  logic [A-1:0]   ram_write_set_addr_out;
  logic [W-1:0]   ram_write_element_out;
  logic [W-1:0]   ram_evict_element_in;

  logic [A-1:0] addr0 = '0, addr1 = '0;
  logic [W-1:0] elem0 = '0, elem1 = '0;
  assign req_set_addr_in = {addr1, addr0};
  assign req_element_in  = {elem1, elem0};

  dual_port_blockram_arbiter #(
    .SINGLE_ELEMENT_SIZE_IN_BITS(W),
    .NUMBER_SETS(N),
    .SET_PTR_WIDTH_IN_BITS(A)
  ) dut (
    .clk_in(clk_in),
    .reset_n_in(reset_n_in),
    .req_valid_in(req_valid_in),
    .req_write_in(req_write_in),
    .req_set_addr_in(req_set_addr_in),
    .req_element_in(req_element_in),
    .req_ready_out(req_ready_out),
    .resp_valid_out(resp_valid_out),
    .resp_element_out(resp_element_out),
    .flush_in(flush_in),
    .flush_evict_valid_out(flush_evict_valid_out),
    .flush_evict_addr_out(flush_evict_addr_out),
    .flush_evict_element_out(flush_evict_element_out),
    .flush_done_out(flush_done_out),
    .init_done_out(init_done_out),
    .ram_read_en_out(ram_read_en_out),
    .ram_read_set_addr_out(ram_read_set_addr_out),
    .ram_read_element_in(ram_read_element_in),
    .ram_write_en_out(ram_write_en_out),
    .ram_write_set_addr_out(ram_write_set_addr_out),
    .ram_write_element_out(ram_write_element_out),
    .ram_evict_element_in(ram_evict_element_in)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural RAM: registered read and evict, read returns pre-write data.
  logic [W-1:0] mem [N];
  always @(posedge clk_in) begin
    if (ram_read_en_out) ram_read_element_in <= mem[ram_read_set_addr_out];
    if (ram_write_en_out) begin
      ram_evict_element_in <= mem[ram_write_set_addr_out];
      mem[ram_write_set_addr_out] <= ram_write_element_out;
    end
  end

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } resp_t;
  typedef struct {
    logic [A-1:0] addr;
    logic [W-1:0] data;
    logic         done;
    int           due;
  } evict_t;

  resp_t  q0[$];
  resp_t  q1[$];
  evict_t fq[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Per-cycle expectations posted by the stimulus.
  logic         chk_ready = 1'b0, chk_init = 1'b0, chk_wr = 1'b0;
  logic [1:0]   exp_ready = 2'b00;
  logic         exp_init = 1'b0;
  logic         exp_wr_en = 1'b0;
  logic [A-1:0] exp_wr_addr = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic missing(input string name, input int due);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: response due at cycle %0d never appeared (now %0d)", name, due, cyc);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk_in) begin
    resp_t  e;
    evict_t f;
    if (chk_ready) check("req_ready", 64'(req_ready_out), 64'(exp_ready));
    if (chk_init)  check("init_done", 64'(init_done_out), 64'(exp_init));
    if (chk_wr) begin
      check("ram_write_en",   64'(ram_write_en_out), 64'(exp_wr_en));
      check("ram_write_addr", 64'(ram_write_set_addr_out), 64'(exp_wr_addr));
      check("ram_write_data", ram_write_element_out, 64'h0);
    end

    while (q0.size() > 0 && q0[0].due < cyc) begin
      missing("resp0", q0[0].due);
      void'(q0.pop_front());
    end
    if (q0.size() > 0 && q0[0].due == cyc) begin
      e = q0.pop_front();
      check("resp0_valid", 64'(resp_valid_out[0]), 64'h1);
      check("resp0_element", resp_element_out[W-1:0], e.data);
    end else begin
      check("resp0_idle", 64'(resp_valid_out[0]), 64'h0);
    end

    while (q1.size() > 0 && q1[0].due < cyc) begin
      missing("resp1", q1[0].due);
      void'(q1.pop_front());
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      check("resp1_valid", 64'(resp_valid_out[1]), 64'h1);
      check("resp1_element", resp_element_out[2*W-1:W], e.data);
    end else begin
      check("resp1_idle", 64'(resp_valid_out[1]), 64'h0);
    end

    while (fq.size() > 0 && fq[0].due < cyc) begin
      missing("flush_evict", fq[0].due);
      void'(fq.pop_front());
    end
    if (fq.size() > 0 && fq[0].due == cyc) begin
      f = fq.pop_front();
      check("flush_evict_valid", 64'(flush_evict_valid_out), 64'h1);
      check("flush_evict_addr", 64'(flush_evict_addr_out), 64'(f.addr));
      check("flush_evict_element", flush_evict_element_out, f.data);
      check("flush_done", 64'(flush_done_out), 64'(f.done));
    end else begin
      check("flush_idle", 64'({flush_evict_valid_out, flush_done_out}), 64'h0);
    end
  end

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
    chk_ready = 1'b0;
    chk_init  = 1'b0;
    chk_wr    = 1'b0;
  endtask

  task automatic expect_ready(input logic [1:0] r);
    chk_ready = 1'b1;
    exp_ready = r;
  endtask

  task automatic expect_init(input logic v);
    chk_init = 1'b1;
    exp_init = v;
  endtask

  task automatic push_resp(input int i, input logic [W-1:0] d);
    resp_t e;
    e.data = d;
    e.due  = cyc + 1;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    $display("issue req%0d at cycle %0d, expect response %h", i, cyc, d);
  endtask

  task automatic push_evict(input int k, input logic [W-1:0] d, input logic done, input int due);
    evict_t f;
    f.addr = A'(k);
    f.data = d;
    f.done = done;
    f.due  = due;
    fq.push_back(f);
    $display("expect flush evict set %0d data %h done %0b at cycle %0d", k, d, done, due);
  endtask

  // Called with reset asserted: hold it two cycles, release, follow the
  // 4-cycle zero sweep, and confirm RUN on the fifth cycle.
  task automatic init_sweep();
    req_valid_in = 2'b11;
    req_write_in = 2'b00;
    repeat (2) begin
      next_cycle();
      expect_ready(2'b00);
      expect_init(1'b0);
    end
    for (int k = 0; k < N; k++) begin
      next_cycle();
      if (k == 0) reset_n_in = 1'b1;
      expect_ready(2'b00);
      expect_init(1'b0);
      chk_wr = 1'b1;
      exp_wr_en = 1'b1;
      exp_wr_addr = A'(k);
      $display("init sweep cycle %0d expects zero write to set %0d", cyc, k);
    end
    next_cycle();
    req_valid_in = 2'b00;
    expect_init(1'b1);
    expect_ready(2'b00);
    chk_wr = 1'b1;
    exp_wr_en = 1'b0;
    exp_wr_addr = '0;
  endtask

  initial begin
    logic [W-1:0] old_vals [N];
    int base;
    old_vals[0] = 64'h11;
    old_vals[1] = 64'h55;
    old_vals[2] = 64'hAA;
    old_vals[3] = 64'h33;

    // 1: reset and INIT sweep
    init_sweep();

    // 2: write set 2 then read it back from the other requester
    next_cycle();
    req_valid_in = 2'b01; req_write_in = 2'b01; addr0 = 2; elem0 = 64'hAA;
    expect_ready(2'b01);
    push_resp(0, 64'h0);
    next_cycle();
    req_valid_in = 2'b10; req_write_in = 2'b00; addr1 = 2;
    expect_ready(2'b10);
    push_resp(1, 64'hAA);

    // 3: both read for 4 cycles, grants alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      req_valid_in = 2'b11; req_write_in = 2'b00; addr0 = 2; addr1 = 3;
      if (k % 2 == 0) begin
        expect_ready(2'b01);
        push_resp(0, 64'hAA);
      end else begin
        expect_ready(2'b10);
        push_resp(1, 64'h0);
      end
    end

    // 4: same-cycle write and read of set 1
    next_cycle();
    req_valid_in = 2'b11; req_write_in = 2'b01; addr0 = 1; elem0 = 64'h55; addr1 = 1;
    expect_ready(2'b11);
    push_resp(0, 64'h0);
`ifdef DUAL_PORT_BLOCKRAM_ARBITER_RAW_FORWARD_EN
    push_resp(1, 64'h55);
`else
    push_resp(1, 64'h0);
`endif

    // Write contention: wr_ptr favours requester 1, then requester 0 retries
    next_cycle();
    req_valid_in = 2'b11; req_write_in = 2'b11;
    addr0 = 0; elem0 = 64'h11; addr1 = 3; elem1 = 64'h33;
    expect_ready(2'b10);
    push_resp(1, 64'h0);
    next_cycle();
    req_valid_in = 2'b01; req_write_in = 2'b01;
    expect_ready(2'b01);
    push_resp(0, 64'h0);

    // 5: fill sets with 1..4, then flush
    for (int k = 0; k < N; k++) begin
      next_cycle();
      req_valid_in = 2'b01; req_write_in = 2'b01; addr0 = A'(k); elem0 = 64'(k + 1);
      expect_ready(2'b01);
      push_resp(0, old_vals[k]);
    end
    next_cycle();
    req_valid_in = 2'b10; req_write_in = 2'b00; addr1 = 3; flush_in = 1'b1;
    expect_ready(2'b10);
    push_resp(1, 64'h4);
    base = cyc;
    for (int k = 0; k < N; k++) push_evict(k, 64'(k + 1), (k == N - 1), base + 2 + k);
    for (int k = 0; k < N; k++) begin
      next_cycle();
      flush_in = 1'b0;
      req_valid_in = 2'b11; req_write_in = 2'b00; addr0 = 0; addr1 = 3;
      expect_ready(2'b00);
      expect_init(1'b0);
    end
    // First RUN cycle: read of a flushed set plus a back-to-back flush
    next_cycle();
    flush_in = 1'b1;
    expect_ready(2'b01);
    expect_init(1'b1);
    push_resp(0, 64'h0);
    base = cyc;
    push_evict(0, 64'h0, 1'b0, base + 2);
    next_cycle();
    flush_in = 1'b0;
    expect_ready(2'b00);
    next_cycle();
    expect_ready(2'b00);

    // 6: reset during FLUSH at counter 2
    next_cycle();
    reset_n_in = 1'b0;
    q0.delete();
    q1.delete();
    fq.delete();
    expect_ready(2'b00);
    expect_init(1'b0);
    $display("reset asserted mid-flush at cycle %0d", cyc);
    init_sweep();

    // Reads after re-init: pointers restarted at 0
    next_cycle();
    req_valid_in = 2'b11; req_write_in = 2'b00; addr0 = 0; addr1 = 3;
    expect_ready(2'b01);
    push_resp(0, 64'h0);
    next_cycle();
    expect_ready(2'b10);
    push_resp(1, 64'h0);
    next_cycle();
    req_valid_in = 2'b00;
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
